beam_power_trigger: RTL and testbench

BEAM_POWER_TRIGGER -- requirements
Module: beam_power_trigger

---
 rtl/pueo_trig_pkg.sv | 21 ++
 rtl/square_sum8.sv | 43 ++++
 rtl/beam_power_trigger.sv | 142 ++++++++++++++
 tb/tb_beam_power_trigger.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pueo_trig_pkg.sv
// Shared widths and FSM encoding for the beam power trigger.
// Widths assume 8 squared samples of 14 bits each, so every sum is exact.
package pueo_trig_pkg;

    localparam int unsigned NSAMP       = 8;
    localparam int unsigned SQBITS      = 14;
    localparam int unsigned PSUM_BITS   = 17;
    localparam int unsigned WSUM_BITS   = 18;
    localparam int unsigned THRESH_BITS = 18;
    localparam int unsigned HOLD_BITS   = 8;
    localparam int unsigned COUNT_BITS  = 16;

    // Larger than any reachable window sum, so nothing triggers out of reset.
    localparam logic [THRESH_BITS-1:0] THRESH_RESET = '1;

    typedef enum logic {
        StIdle,
        StHoldoff
    } trig_state_e;

endpackage

// File: rtl/square_sum8.sv
// Stage 1: balanced adder tree over eight squared samples, registered output.
// The result is exact; PSUM_BITS holds 8 * (2^SQBITS - 1) for the default width.
module square_sum8
    import pueo_trig_pkg::*;
#(
    parameter int unsigned SQBITS = pueo_trig_pkg::SQBITS
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [8*SQBITS-1:0]    sq_i,
    output logic [PSUM_BITS-1:0]   psum_o
);

    logic [PSUM_BITS-1:0] lvl0 [8];
    logic [PSUM_BITS-1:0] lvl1 [4];
    logic [PSUM_BITS-1:0] lvl2 [2];
    logic [PSUM_BITS-1:0] psum_d;
    logic [PSUM_BITS-1:0] psum_q;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lvl0[k] = PSUM_BITS'(sq_i[SQBITS*k +: SQBITS]);
        end
        for (int k = 0; k < 4; k++) begin
            lvl1[k] = lvl0[2*k] + lvl0[2*k+1];
        end
        for (int k = 0; k < 2; k++) begin
            lvl2[k] = lvl1[2*k] + lvl1[2*k+1];
        end
        psum_d = lvl2[0] + lvl2[1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psum_q <= '0;
        end else begin
            psum_q <= psum_d;
        end
    end

    assign psum_o = psum_q;

endmodule

// File: rtl/beam_power_trigger.sv
// Sliding 16-sample beam power trigger: window sum, threshold compare, holdoff FSM,
// threshold update handshake and a saturating trigger counter.
module beam_power_trigger
    import pueo_trig_pkg::*;
#(
    parameter int unsigned HOLDOFF_CLKS = 16,
    parameter int unsigned NSAMP        = pueo_trig_pkg::NSAMP,
    parameter int unsigned SQBITS       = pueo_trig_pkg::SQBITS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NSAMP*SQBITS-1:0]   sq_in_i,
    input  logic [THRESH_BITS-1:0]    thresh_i,
    input  logic                      thresh_valid_i,
    output logic                      thresh_ready_o,
    input  logic                      count_clr_i,
    output logic [WSUM_BITS-1:0]      wsum_o,
    output logic                      trig_o,
    output logic [COUNT_BITS-1:0]     trig_count_o
);

    logic [PSUM_BITS-1:0]   psum;
    logic [PSUM_BITS-1:0]   prev_psum_d, prev_psum_q;
    logic [WSUM_BITS-1:0]   wsum_d, wsum_q;
    logic                   compare_d, compare_q;
    trig_state_e            state_d, state_q;
    logic [HOLD_BITS-1:0]   hold_cnt_d, hold_cnt_q;
    logic [THRESH_BITS-1:0] active_d, active_q;
    logic [THRESH_BITS-1:0] pend_d, pend_q;
    logic                   pend_valid_d, pend_valid_q;
    logic [COUNT_BITS-1:0]  trig_count_d, trig_count_q;
    logic                   trig;
    logic                   take;
    logic                   move;

    square_sum8 #(
        .SQBITS (SQBITS)
    ) u_square_sum8 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sq_i   (sq_in_i),
        .psum_o (psum)
    );

    // Stages 2 and 3: two-clock window and strict compare against the active threshold.
    always_comb begin
        prev_psum_d = psum;
        wsum_d      = WSUM_BITS'(psum) + WSUM_BITS'(prev_psum_q);
        compare_d   = wsum_q > active_q;
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // FSM next state: holdoff spans exactly HOLDOFF_CLKS clocks after the pulse.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (compare_q) begin
                    state_d    = StHoldoff;
                    hold_cnt_d = HOLD_BITS'(HOLDOFF_CLKS);
                end
            end
            StHoldoff: begin
                hold_cnt_d = hold_cnt_q - 8'd1;
                if (hold_cnt_q == 8'd1) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d    = StIdle;
                hold_cnt_d = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        trig = (state_q == StIdle) && compare_q;
    end

    // Threshold handshake: pending only promotes on an idle clock with no pulse.
    always_comb begin
        thresh_ready_o = !pend_valid_q;
        take           = thresh_valid_i && thresh_ready_o;
        move           = pend_valid_q && (state_q == StIdle) && !trig;
        pend_d         = take ? thresh_i : pend_q;
        active_d       = move ? pend_q : active_q;
        pend_valid_d   = pend_valid_q;
        if (move) begin
            pend_valid_d = 1'b0;
        end
        if (take) begin
            pend_valid_d = 1'b1;
        end
    end

    // A clear coincident with a pulse still records that pulse.
    always_comb begin
        trig_count_d = trig_count_q;
        if (count_clr_i) begin
            trig_count_d = trig ? COUNT_BITS'(1) : '0;
        end else if (trig && (trig_count_q != '1)) begin
            trig_count_d = trig_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_psum_q  <= '0;
            wsum_q       <= '0;
            compare_q    <= 1'b0;
            active_q     <= THRESH_RESET;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            trig_count_q <= '0;
        end else begin
            prev_psum_q  <= prev_psum_d;
            wsum_q       <= wsum_d;
            compare_q    <= compare_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            trig_count_q <= trig_count_d;
        end
    end

    assign wsum_o       = wsum_q;
    assign trig_o       = trig;
    assign trig_count_o = trig_count_q;

endmodule

// File: tb/tb_beam_power_trigger.sv
// Self-checking bench for beam_power_trigger against a cycle-indexed history model.
module tb_beam_power_trigger;

    localparam int H    = 16;
    localparam int NS   = 8;
    localparam int SQ   = 14;
    localparam int MAXC = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NS*SQ-1:0]  sq_in = '0;
    logic [17:0]       thresh = '0;
    logic              thresh_valid = 1'b0;
    logic              thresh_ready;
    logic              count_clr = 1'b0;
    logic [17:0]       wsum;
    logic              trig;
    logic [15:0]       trig_count;

    always #5 clk = ~clk;

    beam_power_trigger #(
        .HOLDOFF_CLKS (H),
        .NSAMP        (NS),
        .SQBITS       (SQ)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sq_in_i        (sq_in),
        .thresh_i       (thresh),
        .thresh_valid_i (thresh_valid),
        .thresh_ready_o (thresh_ready),
        .count_clr_i    (count_clr),
        .wsum_o         (wsum),
        .trig_o         (trig),
        .trig_count_o   (trig_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-cycle histories indexed by cycles since reset.
    int unsigned p_hist [MAXC];
    int unsigned w_hist [MAXC];
    int unsigned a_hist [MAXC];
    int          rc        = 0;
    int          last_trig = -1000;
    bit          pend_v    = 1'b0;
    int unsigned pend_t    = 0;
    int unsigned cnt_m     = 0;
    logic [17:0] exp_wsum  = '0;
    logic        exp_trig  = 1'b0;
    logic        exp_ready = 1'b1;
    logic        exp_idle  = 1'b1;
    logic [15:0] exp_count = '0;

    function automatic int unsigned drive_sum();
        int unsigned s = 0;
        for (int k = 0; k < NS; k++) begin
            s += {18'd0, sq_in[SQ*k +: SQ]};
        end
        return s;
    endfunction

    task automatic model_expect();
        int unsigned w = 0;
        bit cmp = 1'b0;
        if (rc >= 2) w += p_hist[rc-2];
        if (rc >= 3) w += p_hist[rc-3];
        w_hist[rc] = w;
        if (rc >= 1) cmp = w_hist[rc-1] > a_hist[rc-1];
        exp_wsum  = 18'(w);
        exp_idle  = (rc - last_trig) > H;
        exp_trig  = cmp && exp_idle;
        exp_ready = !pend_v;
        exp_count = 16'(cnt_m);
    endtask

    task automatic model_update();
        if (rst) begin
            rc        = 0;
            a_hist[0] = 32'h3FFFF;
            pend_v    = 1'b0;
            cnt_m     = 0;
            last_trig = -1000;
        end else begin
            p_hist[rc] = drive_sum();
            if (exp_trig) last_trig = rc;
            if (count_clr) cnt_m = exp_trig ? 1 : 0;
            else if (exp_trig && cnt_m < 65535) cnt_m++;
            if (pend_v && exp_idle && !exp_trig) begin
                a_hist[rc+1] = pend_t;
                pend_v = 1'b0;
            end else begin
                a_hist[rc+1] = a_hist[rc];
            end
            if (thresh_valid && exp_ready) begin
                pend_v = 1'b1;
                pend_t = 32'(thresh);
            end
            if (rc < MAXC - 2) rc++;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        model_expect();
    endtask

    task automatic set_all(input int unsigned v);
        for (int k = 0; k < NS; k++) sq_in[SQ*k +: SQ] = 14'(v);
    endtask

    task automatic set_rand();
        for (int k = 0; k < NS; k++) sq_in[SQ*k +: SQ] = 14'($urandom_range(0, 16383));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        thresh_valid = 1'b0;
        count_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic load_thresh(input int unsigned t);
        thresh = 18'(t);
        thresh_valid = 1'b1;
        step();
        thresh_valid = 1'b0;
    endtask

    task automatic wait_trig(input string name);
        int w = 0;
        while (trig !== 1'b1 && w < 10) begin
            step();
            w++;
        end
        n_checks++;
        if (trig !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_first_trig: trig_o=%b after %0d clocks, required 1", name, trig, w);
        end
    endtask

    task automatic test_reset();
        set_all(16383);
        do_reset();
        n_checks += 4;
        if (wsum !== 18'd0) begin n_fail++; $display("FAIL reset_wsum: got %0d want 0", wsum); end
        if (trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %b want 0", trig); end
        if (thresh_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", thresh_ready);
        end
        if (trig_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", trig_count);
        end
        step();
        n_checks++;
        if (wsum !== 18'd0) begin n_fail++; $display("FAIL refill_wsum1: got %0d want 0", wsum); end
        step();
        n_checks++;
        if (wsum !== 18'd131064) begin
            n_fail++; $display("FAIL refill_wsum2: got %0d want 131064", wsum);
        end
    endtask

    task automatic test_steady();
        int first_w = -1;
        int first_t = -1;
        int prev_t = -1;
        int ntrig = 0;
        set_all(0);
        do_reset();
        load_thresh(15000);
        set_all(1000);
        for (int i = 0; i < 80; i++) begin
            n_checks += 2;
            if (wsum !== exp_wsum) begin
                n_fail++; $display("FAIL steady_wsum i=%0d: got %0d want %0d", i, wsum, exp_wsum);
            end
            if (trig !== exp_trig) begin
                n_fail++; $display("FAIL steady_trig i=%0d: got %b want %b", i, trig, exp_trig);
            end
            if (wsum === 18'd16000 && first_w < 0) first_w = i;
            if (trig === 1'b1) begin
                if (prev_t >= 0) begin
                    n_checks++;
                    if (i - prev_t != H + 1) begin
                        n_fail++; $display("FAIL steady_period: got %0d want %0d", i - prev_t, H + 1);
                    end
                end else begin
                    first_t = i;
                end
                prev_t = i;
                ntrig++;
            end
            step();
        end
        n_checks += 4;
        if (first_w != 3) begin n_fail++; $display("FAIL steady_wsum_lat: got %0d want 3", first_w); end
        if (first_t != 4) begin n_fail++; $display("FAIL steady_trig_lat: got %0d want 4", first_t); end
        if (ntrig != 5) begin n_fail++; $display("FAIL steady_ntrig: got %0d want 5", ntrig); end
        if (trig_count !== 16'd5) begin
            n_fail++; $display("FAIL steady_count: got %0d want 5", trig_count);
        end
    endtask

    task automatic pulse_run(input int unsigned thr, output int ntrig, output int nw16);
        ntrig = 0;
        nw16 = 0;
        set_all(0);
        do_reset();
        load_thresh(thr);
        step();
        step();
        set_all(2000);
        step();
        set_all(0);
        for (int i = 0; i < 30; i++) begin
            n_checks += 2;
            if (wsum !== exp_wsum) begin
                n_fail++; $display("FAIL pulse_wsum thr=%0d: got %0d want %0d", thr, wsum, exp_wsum);
            end
            if (trig !== exp_trig) begin
                n_fail++; $display("FAIL pulse_trig thr=%0d: got %b want %b", thr, trig, exp_trig);
            end
            if (wsum === 18'd16000) nw16++;
            if (trig === 1'b1) ntrig++;
            step();
        end
    endtask

    task automatic test_boundary();
        int nt;
        int nw;
        pulse_run(15999, nt, nw);
        n_checks += 2;
        if (nt != 1) begin n_fail++; $display("FAIL bound_15999_ntrig: got %0d want 1", nt); end
        if (nw != 2) begin n_fail++; $display("FAIL bound_15999_nw16: got %0d want 2", nw); end
        pulse_run(16000, nt, nw);
        n_checks += 2;
        if (nt != 0) begin n_fail++; $display("FAIL bound_16000_ntrig: got %0d want 0", nt); end
        if (nw != 2) begin n_fail++; $display("FAIL bound_16000_nw16: got %0d want 2", nw); end
    endtask

    task automatic test_max();
        int ntrig = 0;
        int maxw = 0;
        set_all(0);
        do_reset();
        load_thresh(262119);
        set_all(16383);
        for (int i = 0; i < 30; i++) begin
            n_checks++;
            if (wsum !== exp_wsum) begin
                n_fail++; $display("FAIL max_wsum: got %0d want %0d", wsum, exp_wsum);
            end
            if (int'(wsum) > maxw) maxw = int'(wsum);
            if (trig === 1'b1) ntrig++;
            step();
        end
        n_checks += 2;
        if (maxw != 262128) begin n_fail++; $display("FAIL max_peak: got %0d want 262128", maxw); end
        if (ntrig != 2) begin n_fail++; $display("FAIL max_ntrig: got %0d want 2", ntrig); end
        set_all(0);
        do_reset();
        load_thresh(262128);
        set_all(16383);
        ntrig = 0;
        for (int i = 0; i < 30; i++) begin
            if (trig === 1'b1) ntrig++;
            step();
        end
        n_checks++;
        if (ntrig != 0) begin n_fail++; $display("FAIL max_equal_ntrig: got %0d want 0", ntrig); end
    endtask

    task automatic test_holdoff_update();
        int nlow = 0;
        int ntrig = 0;
        set_all(0);
        do_reset();
        load_thresh(100);
        set_all(1000);
        wait_trig("holdoff");
        set_all(0);
        step();
        thresh = 18'd20000;
        thresh_valid = 1'b1;
        step();
        thresh_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            n_checks += 2;
            if (thresh_ready !== exp_ready) begin
                n_fail++; $display("FAIL hold_ready i=%0d: got %b want %b", i, thresh_ready, exp_ready);
            end
            if (trig !== exp_trig) begin
                n_fail++; $display("FAIL hold_trig i=%0d: got %b want %b", i, trig, exp_trig);
            end
            if (thresh_ready === 1'b0) nlow++;
            step();
        end
        n_checks++;
        if (nlow != H) begin n_fail++; $display("FAIL hold_ready_low: got %0d want %0d", nlow, H); end
        set_all(1000);
        for (int i = 0; i < 20; i++) begin
            if (trig === 1'b1) ntrig++;
            step();
        end
        n_checks++;
        if (ntrig != 0) begin n_fail++; $display("FAIL hold_new_thresh: got %0d want 0", ntrig); end
    endtask

    task automatic test_saturate();
        set_all(0);
        do_reset();
        load_thresh(100);
        set_all(1000);
        force dut.trig_count_q = 16'd65533;
        #1;
        release dut.trig_count_q;
        cnt_m = 65533;
        exp_count = 16'd65533;
        for (int i = 0; i < 50; i++) begin
            n_checks++;
            if (trig_count !== exp_count) begin
                n_fail++; $display("FAIL sat_count i=%0d: got %0d want %0d", i, trig_count, exp_count);
            end
            step();
        end
        n_checks++;
        if (trig_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_hold: got %0d want 65535", trig_count);
        end
        wait_trig("sat");
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        n_checks++;
        if (trig_count !== 16'd1) begin
            n_fail++; $display("FAIL sat_clr_with_trig: got %0d want 1", trig_count);
        end
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        n_checks++;
        if (trig_count !== 16'd0) begin
            n_fail++; $display("FAIL sat_clr_alone: got %0d want 0", trig_count);
        end
    endtask

    task automatic test_reset_mid();
        int ntrig = 0;
        set_all(0);
        do_reset();
        load_thresh(100);
        set_all(1000);
        wait_trig("rstmid");
        step();
        step();
        thresh = 18'd5000;
        thresh_valid = 1'b1;
        step();
        thresh_valid = 1'b0;
        n_checks++;
        if (thresh_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_pending: got %b want 0", thresh_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks += 4;
        if (wsum !== 18'd0) begin n_fail++; $display("FAIL rstmid_wsum: got %0d want 0", wsum); end
        if (trig !== 1'b0) begin n_fail++; $display("FAIL rstmid_trig: got %b want 0", trig); end
        if (thresh_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_ready: got %b want 1", thresh_ready);
        end
        if (trig_count !== 16'd0) begin
            n_fail++; $display("FAIL rstmid_count: got %0d want 0", trig_count);
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (wsum !== exp_wsum) begin
                n_fail++; $display("FAIL rstmid_refill: got %0d want %0d", wsum, exp_wsum);
            end
            if (trig === 1'b1) ntrig++;
            step();
        end
        n_checks++;
        if (ntrig != 0) begin n_fail++; $display("FAIL rstmid_ntrig: got %0d want 0", ntrig); end
    endtask

    task automatic test_random();
        set_all(0);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_rand();
            thresh = 18'($urandom_range(110000, 160000));
            thresh_valid = ($urandom_range(0, 3) == 0);
            count_clr = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 249) == 0);
            n_checks += 4;
            if (wsum !== exp_wsum) begin
                n_fail++; $display("FAIL rand_wsum i=%0d: got %0d want %0d", i, wsum, exp_wsum);
            end
            if (trig !== exp_trig) begin
                n_fail++; $display("FAIL rand_trig i=%0d: got %b want %b", i, trig, exp_trig);
            end
            if (thresh_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready i=%0d: got %b want %b", i, thresh_ready, exp_ready);
            end
            if (trig_count !== exp_count) begin
                n_fail++; $display("FAIL rand_count i=%0d: got %0d want %0d", i, trig_count, exp_count);
            end
            step();
        end
        rst = 1'b0;
        thresh_valid = 1'b0;
        count_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_steady();
        test_boundary();
        test_max();
        test_holdoff_update();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
